qu_rob_mc: RTL and testbench

Parametrised multi-commit reorder buffer for the Qu out-of-order core.
- Allocates one entry per cycle at dispatch, in program order.
- Tracks execution state of each entry and captures results from the common data bus.
- Retires up to COMMIT_W completed entries per cycle, in order, to physical RF commit logic.
- Provides a combinational operand lookup port for reservation-station tag resolution.
- Sits between dispatch/rename and the reservation stations/physical register file.

---
 rtl/qu_common.sv | 34 +++
 rtl/qu_rob_mc_if.sv | 56 +++++
 rtl/qu_rob_commit_sel.sv | 42 ++++
 rtl/qu_rob_mc.sv | 122 ++++++++++++
 tb/tb_qu_rob_mc.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qu_common.sv
`default_nettype none
// ============================================================================
// Module      : qu_common (package)
// Description : Shared Qu core constants and types used by the reorder buffer:
//               ROB geometry defaults, entry state encoding, pointer and cell
//               types.
// Revision    : 1.0 - initial release
// ============================================================================
package qu_common;

   localparam int ROB_DEPTH         = 8;
   localparam int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH);
   localparam int ROB_DATA_WIDTH    = 32;
   localparam int PHY_RF_ADDR_WIDTH = 7;
   localparam int ROB_COMMIT_WIDTH  = 2;

   typedef logic [1:0] rob_state_t;

   localparam rob_state_t ROB_STATE_EMPTY   = 2'd0;
   localparam rob_state_t ROB_STATE_PENDING = 2'd1;
   localparam rob_state_t ROB_STATE_EXECUTE = 2'd2;
   localparam rob_state_t ROB_STATE_RETIRED = 2'd3;

   // Head/tail pointer: index bits plus a wrap bit in the MSB
   typedef logic [ROB_ADDR_WIDTH:0] rob_ptr_t;

   typedef struct packed {
      rob_state_t                     state;
      logic [PHY_RF_ADDR_WIDTH-1:0]   dest;
      logic [ROB_DATA_WIDTH-1:0]      value;
   } rob_cell_t;

endpackage
`default_nettype wire

// File: rtl/qu_rob_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : qu_rob_mc_if
// Description : Bus bundle of the multi-commit reorder buffer.
//               master : dispatch / execution / commit-consumer side
//               slave  : the reorder buffer itself
//               Groups: allocation (alloc_*), exec tracking (exec_*),
//               CDB writeback (wb_*), commit lanes (commit_*), operand
//               lookup (rd_*), flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
interface qu_rob_mc_if
   import qu_common::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int COMMIT_W = ROB_COMMIT_WIDTH,
   parameter int DATA_W   = ROB_DATA_WIDTH,
   parameter int DEST_W   = PHY_RF_ADDR_WIDTH
);
   localparam int AW = $clog2(DEPTH);

   logic                         alloc_valid;
   logic [DEST_W-1:0]            alloc_dest;
   logic                         alloc_ready;
   logic [AW-1:0]                alloc_idx;
   logic                         exec_valid;
   logic [AW-1:0]                exec_idx;
   logic                         wb_valid;
   logic [AW-1:0]                wb_idx;
   logic [DATA_W-1:0]            wb_value;
   logic                         commit_ready;
   logic [COMMIT_W-1:0]          commit_valid;
   logic [COMMIT_W*DEST_W-1:0]   commit_dest;
   logic [COMMIT_W*DATA_W-1:0]   commit_value;
   logic [AW-1:0]                rd_idx;
   logic                         rd_done;
   logic [DATA_W-1:0]            rd_value;
   logic                         flush;
   logic [AW:0]                  count;

   modport master (
      output alloc_valid, alloc_dest, exec_valid, exec_idx,
             wb_valid, wb_idx, wb_value, commit_ready, rd_idx, flush,
      input  alloc_ready, alloc_idx, commit_valid, commit_dest,
             commit_value, rd_done, rd_value, count
   );

   modport slave (
      input  alloc_valid, alloc_dest, exec_valid, exec_idx,
             wb_valid, wb_idx, wb_value, commit_ready, rd_idx, flush,
      output alloc_ready, alloc_idx, commit_valid, commit_dest,
             commit_value, rd_done, rd_value, count
   );

endinterface
`default_nettype wire

// File: rtl/qu_rob_commit_sel.sv
`default_nettype none
// ============================================================================
// Module      : qu_rob_commit_sel
// Description : Commit lane selector. Given the states of the COMMIT_W
//               entries starting at head and the occupancy, produces the
//               in-order prefix mask of committable lanes and its popcount.
// Ports       : i_lane_state - per-lane entry state, lane 0 = head
//               i_count      - ROB occupancy
//               o_valid      - prefix-valid commit mask
//               o_ncommit    - number of set bits in o_valid
// Revision    : 1.0 - initial release
// ============================================================================
module qu_rob_commit_sel
   import qu_common::*;
#(
   parameter int COMMIT_W = ROB_COMMIT_WIDTH,
   parameter int AW       = ROB_ADDR_WIDTH
) (
   input  rob_state_t [COMMIT_W-1:0] i_lane_state,
   input  logic [AW:0]               i_count,
   output logic [COMMIT_W-1:0]       o_valid,
   output logic [AW:0]               o_ncommit
);

   logic w_run;

   // w_run stays high only while every older lane is committable, which
   // makes o_valid a contiguous run of ones from lane 0.
   always_comb begin
      o_valid   = '0;
      o_ncommit = '0;
      w_run     = 1'b1;
      for (int i = 0; i < COMMIT_W; i++) begin
         w_run      = w_run && ((AW+1)'(i) < i_count) &&
                      (i_lane_state[i] == ROB_STATE_RETIRED);
         o_valid[i] = w_run;
         o_ncommit  = o_ncommit + {{AW{1'b0}}, w_run};
      end
   end

endmodule
`default_nettype wire

// File: rtl/qu_rob_mc.sv
`default_nettype none
// ============================================================================
// Module      : qu_rob_mc
// Description : Multi-commit reorder buffer. Allocates one entry per cycle
//               in program order, tracks exec / writeback state, retires up
//               to COMMIT_W completed entries per cycle in order, and offers
//               a combinational operand lookup port.
// Ports       : clk   - clock
//               rst_n - synchronous reset, active low
//               bus   - qu_rob_mc_if.slave (alloc, exec, wb, commit,
//                       lookup, flush, count)
// Revision    : 1.0 - initial release
// ============================================================================
module qu_rob_mc
   import qu_common::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int COMMIT_W = ROB_COMMIT_WIDTH,
   parameter int DATA_W   = ROB_DATA_WIDTH,
   parameter int DEST_W   = PHY_RF_ADDR_WIDTH,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   qu_rob_mc_if.slave     bus
);

   rob_state_t          r_state [DEPTH];
   logic [DEST_W-1:0]   r_dest  [DEPTH];
   logic [DATA_W-1:0]   r_value [DEPTH];
   logic [AW:0]         r_head;
   logic [AW:0]         r_tail;
   logic [AW:0]         r_count;

   logic [AW-1:0]             w_lane_idx [COMMIT_W];
   rob_state_t [COMMIT_W-1:0] w_lane_state;
   logic [COMMIT_W-1:0]       w_commit_valid;
   logic [AW:0]               w_ncommit;
   logic [AW:0]               w_ncommit_eff;
   logic                      w_full;
   logic                      w_alloc_fire;

   // ---------------------------------------------------------------------
   // Commit lanes: lane i looks at entry head+i (modulo DEPTH)
   // ---------------------------------------------------------------------
   for (genvar gl = 0; gl < COMMIT_W; gl++) begin : g_lane
      assign w_lane_idx[gl]   = r_head[AW-1:0] + AW'(gl);
      assign w_lane_state[gl] = r_state[w_lane_idx[gl]];
      assign bus.commit_dest [gl*DEST_W +: DEST_W] = r_dest [w_lane_idx[gl]];
      assign bus.commit_value[gl*DATA_W +: DATA_W] = r_value[w_lane_idx[gl]];
   end

   qu_rob_commit_sel #(
      .COMMIT_W (COMMIT_W),
      .AW       (AW)
   ) u_commit_sel (
      .i_lane_state (w_lane_state),
      .i_count      (r_count),
      .o_valid      (w_commit_valid),
      .o_ncommit    (w_ncommit)
   );

   assign bus.commit_valid = w_commit_valid;
   assign w_ncommit_eff    = bus.commit_ready ? w_ncommit : '0;

   // ---------------------------------------------------------------------
   // Allocation: no same-cycle commit bypass, a full ROB always refuses
   // ---------------------------------------------------------------------
   assign w_full          = (r_count == (AW+1)'(DEPTH));
   assign bus.alloc_ready = !w_full && !bus.flush;
   assign w_alloc_fire    = bus.alloc_valid && bus.alloc_ready;
   assign bus.alloc_idx   = r_tail[AW-1:0];
   assign bus.count       = r_count;

   // Lookup reads registered state only; same-cycle writeback is not seen
   assign bus.rd_done  = (r_state[bus.rd_idx] == ROB_STATE_RETIRED);
   assign bus.rd_value = r_value[bus.rd_idx];

   // ---------------------------------------------------------------------
   // State update. Flush lands in the same clearing path as reset; reset
   // still dominates since both produce the same result.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i] <= ROB_STATE_EMPTY;
            r_dest[i]  <= '0;
            r_value[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (bus.exec_valid && (r_state[bus.exec_idx] == ROB_STATE_PENDING)) begin
            r_state[bus.exec_idx] <= ROB_STATE_EXECUTE;
         end
         // Placed after exec so a same-entry writeback overrides it
         if (bus.wb_valid && ((r_state[bus.wb_idx] == ROB_STATE_PENDING) ||
                              (r_state[bus.wb_idx] == ROB_STATE_EXECUTE))) begin
            r_value[bus.wb_idx] <= bus.wb_value;
            r_state[bus.wb_idx] <= ROB_STATE_RETIRED;
         end
         // Committing entries are RETIRED and the tail entry is EMPTY, so
         // none of these writes can collide with exec/wb/alloc above/below.
         for (int l = 0; l < COMMIT_W; l++) begin
            if (bus.commit_ready && w_commit_valid[l]) begin
               r_state[w_lane_idx[l]] <= ROB_STATE_EMPTY;
            end
         end
         if (w_alloc_fire) begin
            r_state[r_tail[AW-1:0]] <= ROB_STATE_PENDING;
            r_dest [r_tail[AW-1:0]] <= bus.alloc_dest;
            r_value[r_tail[AW-1:0]] <= '0;
         end
         r_head  <= r_head + w_ncommit_eff;
         r_tail  <= r_tail + {{AW{1'b0}}, w_alloc_fire};
         r_count <= r_count + {{AW{1'b0}}, w_alloc_fire} - w_ncommit_eff;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qu_rob_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_qu_rob_mc
// Description : Self-checking bench for qu_rob_mc. A program-order queue
//               model predicts occupancy, commit lanes and lookup results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qu_rob_mc;

   localparam int DEPTH    = 8;
   localparam int COMMIT_W = 2;
   localparam int DATA_W   = 32;
   localparam int DEST_W   = 7;
   localparam int AW       = 3;

   // model entry states
   localparam int S_FREE = 0;
   localparam int S_WAIT = 1;
   localparam int S_RUN  = 2;
   localparam int S_DONE = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   qu_rob_mc_if #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W),
                  .DEST_W(DEST_W)) bus ();

   qu_rob_mc #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W),
               .DEST_W(DEST_W), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int                m_st   [DEPTH];
   logic [DATA_W-1:0] m_val  [DEPTH];
   logic [DEST_W-1:0] m_dest [DEPTH];
   int                q [$];   // entry indices, oldest first
   int                m_tail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_st[i] = S_FREE; m_val[i] = '0; m_dest[i] = '0;
      end
      q.delete();
      m_tail = 0;
   endfunction

   function automatic int exp_ncommit();
      int n = 0;
      while (n < COMMIT_W && n < q.size() && m_st[q[n]] == S_DONE) n++;
      return n;
   endfunction

   task automatic idle();
      bus.alloc_valid  = 1'b0; bus.alloc_dest = '0;
      bus.exec_valid   = 1'b0; bus.exec_idx   = '0;
      bus.wb_valid     = 1'b0; bus.wb_idx     = '0; bus.wb_value = '0;
      bus.commit_ready = 1'b0; bus.flush      = 1'b0;
   endtask

   // Settle, then compare every output against the model
   task automatic settle_check();
      int nc;
      logic [COMMIT_W-1:0] ev;
      #1;
      nc = exp_ncommit();
      ev = '0;
      for (int i = 0; i < nc; i++) ev[i] = 1'b1;
      check("alloc_ready", 64'(bus.alloc_ready), 64'(q.size() < DEPTH && !bus.flush));
      check("alloc_idx", 64'(bus.alloc_idx), 64'(m_tail));
      check("count", 64'(bus.count), 64'(q.size()));
      check("commit_valid", 64'(bus.commit_valid), 64'(ev));
      for (int i = 0; i < nc; i++) begin
         check("commit_dest", 64'(bus.commit_dest[i*DEST_W +: DEST_W]), 64'(m_dest[q[i]]));
         check("commit_value", 64'(bus.commit_value[i*DATA_W +: DATA_W]), 64'(m_val[q[i]]));
      end
      check("rd_done", 64'(bus.rd_done), 64'(m_st[bus.rd_idx] == S_DONE));
      if (m_st[bus.rd_idx] == S_DONE)
         check("rd_value", 64'(bus.rd_value), 64'(m_val[bus.rd_idx]));
   endtask

   // Clock edge plus model update from the inputs held across it
   task automatic advance();
      int  nc;
      bit  a;
      nc = exp_ncommit();
      @(posedge clk);
      if (!rst_n || bus.flush) begin
         m_clear();
      end else begin
         a = bus.alloc_valid && (q.size() < DEPTH);
         if (bus.exec_valid && m_st[bus.exec_idx] == S_WAIT) m_st[bus.exec_idx] = S_RUN;
         if (bus.wb_valid && (m_st[bus.wb_idx] == S_WAIT || m_st[bus.wb_idx] == S_RUN)) begin
            m_val[bus.wb_idx] = bus.wb_value;
            m_st[bus.wb_idx]  = S_DONE;
         end
         if (bus.commit_ready) begin
            repeat (nc) begin
               m_st[q[0]] = S_FREE;
               void'(q.pop_front());
            end
         end
         if (a) begin
            m_st[m_tail]   = S_WAIT;
            m_dest[m_tail] = bus.alloc_dest;
            m_val[m_tail]  = '0;
            q.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      #1;
   endtask

   task automatic cycle();
      settle_check();
      advance();
   endtask

   task automatic wb(input int idx, input logic [DATA_W-1:0] v);
      bus.wb_valid = 1'b1; bus.wb_idx = AW'(idx); bus.wb_value = v;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rd_idx = '0;
      idle();
      m_clear();
      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst_n = 1'b1;

      // ---- 1: fill with dest 10..17, then an ignored 9th request ----
      for (int i = 0; i < DEPTH; i++) begin
         idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(10 + i);
         settle_check();
         check("fill_alloc_idx", 64'(bus.alloc_idx), 64'(i));
         advance();
      end
      idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(99);
      settle_check();
      check("full_ready", 64'(bus.alloc_ready), 64'(0));
      check("full_count", 64'(bus.count), 64'(8));
      advance();

      // ---- 2: out-of-order writebacks, then a 2-wide commit ----
      idle(); bus.commit_ready = 1'b1; wb(1, 32'hB); cycle();
      idle(); bus.commit_ready = 1'b1; wb(0, 32'hA); cycle();
      idle(); bus.commit_ready = 1'b1;
      settle_check();
      check("dual_valid", 64'(bus.commit_valid), 64'(2'b11));
      check("dual_dest0", 64'(bus.commit_dest[0 +: DEST_W]), 64'(10));
      check("dual_dest1", 64'(bus.commit_dest[DEST_W +: DEST_W]), 64'(11));
      check("dual_val0", 64'(bus.commit_value[0 +: DATA_W]), 64'(32'hA));
      check("dual_val1", 64'(bus.commit_value[DATA_W +: DATA_W]), 64'(32'hB));
      advance();
      idle();
      settle_check();
      check("dual_count", 64'(bus.count), 64'(6));
      advance();

      // ---- 3: younger entry done, head blocks; lookup sees it ----
      idle(); bus.commit_ready = 1'b1; wb(3, 32'hB); cycle();
      idle(); bus.commit_ready = 1'b1; bus.rd_idx = 3'd3;
      settle_check();
      check("block_valid", 64'(bus.commit_valid), 64'(0));
      check("lookup_done", 64'(bus.rd_done), 64'(1));
      check("lookup_val", 64'(bus.rd_value), 64'(32'hB));
      advance();

      // ---- 4: walk head to 7, then commit 2 + alloc 1 across the wrap ----
      idle(); wb(2, 32'h2); cycle();
      idle(); wb(4, 32'h4); cycle();
      idle(); wb(5, 32'h5); cycle();
      idle(); wb(6, 32'h6); cycle();
      repeat (3) begin idle(); bus.commit_ready = 1'b1; cycle(); end
      for (int i = 0; i < 3; i++) begin
         idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(20 + i); cycle();
      end
      idle(); wb(7, 32'h77); cycle();
      idle(); wb(0, 32'h70); cycle();
      idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(23);
      bus.commit_ready = 1'b1; bus.rd_idx = 3'd7;
      settle_check();
      check("wrap_valid", 64'(bus.commit_valid), 64'(2'b11));
      check("wrap_dest0", 64'(bus.commit_dest[0 +: DEST_W]), 64'(17));
      check("wrap_count_pre", 64'(bus.count), 64'(4));
      advance();
      idle();
      settle_check();
      check("wrap_count_post", 64'(bus.count), 64'(3));
      check("wrap_alloc_idx", 64'(bus.alloc_idx), 64'(4));
      check("wrap_rd7_empty", 64'(bus.rd_done), 64'(0));
      advance();

      // ---- 5: fill with mixed states, then flush with alloc + wb ----
      for (int i = 0; i < 5; i++) begin
         idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(30 + i);
         if (i == 0) begin bus.exec_valid = 1'b1; bus.exec_idx = 3'd1; wb(2, 32'h22); end
         cycle();
      end
      idle(); bus.flush = 1'b1; bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(5);
      wb(3, 32'h33); bus.commit_ready = 1'b1;
      settle_check();
      check("flush_full", 64'(bus.count), 64'(8));
      advance();
      idle(); wb(3, 32'h99);
      settle_check();
      check("flush_count", 64'(bus.count), 64'(0));
      check("flush_alloc_idx", 64'(bus.alloc_idx), 64'(0));
      advance();
      for (int i = 0; i < DEPTH; i++) begin
         idle(); bus.rd_idx = AW'(i);
         settle_check();
         check("flush_empty", 64'(bus.rd_done), 64'(0));
         advance();
      end

      // ---- 6: exec+wb same entry; exec on an empty entry ----
      idle(); bus.alloc_valid = 1'b1; bus.alloc_dest = DEST_W'(40); cycle();
      idle(); bus.exec_valid = 1'b1; bus.exec_idx = 3'd0; wb(0, 32'h66); cycle();
      idle(); bus.rd_idx = 3'd0;
      settle_check();
      check("exwb_done", 64'(bus.rd_done), 64'(1));
      check("exwb_val", 64'(bus.rd_value), 64'(32'h66));
      advance();
      idle(); bus.exec_valid = 1'b1; bus.exec_idx = 3'd5; cycle();
      idle(); wb(5, 32'h55); cycle();
      idle(); bus.rd_idx = 3'd5;
      settle_check();
      check("exec_empty_ign", 64'(bus.rd_done), 64'(0));
      advance();

      // ---- random traffic against the model ----
      for (int n = 0; n < 500; n++) begin
         idle();
         rst_n            = ($urandom_range(0, 99) != 0);
         bus.alloc_valid  = ($urandom_range(0, 99) < 55);
         bus.alloc_dest   = DEST_W'($urandom);
         bus.exec_valid   = ($urandom_range(0, 1) == 1);
         bus.exec_idx     = AW'($urandom);
         bus.wb_valid     = ($urandom_range(0, 99) < 60);
         if (q.size() > 0 && $urandom_range(0, 4) != 0)
            bus.wb_idx = AW'(q[$urandom_range(0, q.size() - 1)]);
         else
            bus.wb_idx = AW'($urandom);
         bus.wb_value     = $urandom;
         bus.commit_ready = ($urandom_range(0, 99) < 70);
         bus.flush        = ($urandom_range(0, 39) == 0);
         bus.rd_idx       = AW'($urandom);
         cycle();
      end
      rst_n = 1'b1;
      idle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
